// File: rtl/fp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_arbiter: round-robin sharing of one fp_unit between NREQ requesters,  |
// | one operation in flight, with timeout and a valid/ready response buffer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data1,
  input  logic [NREQ*32-1:0]   req_data2,
  input  logic [NREQ*32-1:0]   req_data3,
  input  logic [NREQ*3-1:0]    req_rm,
  input  logic [NREQ*10-1:0]   req_opcode,
  input  logic [NREQ*2-1:0]    req_cvt_op,
  output logic [31:0]          fpu_data1,
  output logic [31:0]          fpu_data2,
  output logic [31:0]          fpu_data3,
  output logic [2:0]           fpu_rm,
  output logic [9:0]           fpu_opcode,
  output logic [1:0]           fpu_cvt_op,
  output logic                 fpu_enable,
  input  logic [31:0]          fpu_result,
  input  logic [4:0]           fpu_flags,
  input  logic                 fpu_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
  localparam logic [4:0]  c_flags_nv = 5'b10000;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gid;
  logic [15:0]     r_cnt;

  logic [31:0]     w_d1  [NREQ];
  logic [31:0]     w_d2  [NREQ];
  logic [31:0]     w_d3  [NREQ];
  logic [2:0]      w_rm  [NREQ];
  logic [9:0]      w_op  [NREQ];
  logic [1:0]      w_cvt [NREQ];

  logic            w_found;
  logic [PW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_gnt_oh;
  logic [NREQ-1:0] w_gid_oh;
  logic            w_accept;
  logic [9:0]      w_sel_op;
  logic            w_op_legal;
  logic [PW-1:0]   w_ptr_next;
  logic [16:0]     w_cnt_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_d1[gi]  = req_data1[32*gi +: 32];
      assign w_d2[gi]  = req_data2[32*gi +: 32];
      assign w_d3[gi]  = req_data3[32*gi +: 32];
      assign w_rm[gi]  = req_rm[3*gi +: 3];
      assign w_op[gi]  = req_opcode[10*gi +: 10];
      assign w_cvt[gi] = req_cvt_op[2*gi +: 2];
    end
  endgenerate

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_gnt_oh  = w_found ? (NREQ'(1) << w_gnt_idx) : '0;
  assign req_ready = (r_state == c_idle && !reset) ? w_gnt_oh : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_gid_oh  = NREQ'(1) << r_gid;

  assign w_sel_op   = w_op[w_gnt_idx];
  assign w_op_legal = (w_sel_op != 10'd0) &&
                      ((w_sel_op & (w_sel_op - 10'd1)) == 10'd0) &&
                      !w_sel_op[7];

  assign w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
  assign w_cnt_next = {1'b0, r_cnt} + 17'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_idle;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_cnt       <= '0;
      fpu_data1   <= '0;
      fpu_data2   <= '0;
      fpu_data3   <= '0;
      fpu_rm      <= '0;
      fpu_opcode  <= '0;
      fpu_cvt_op  <= '0;
      fpu_enable  <= 1'b0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_gid <= w_gnt_idx;
            r_ptr <= w_ptr_next;
            busy  <= 1'b1;
            if (w_op_legal) begin
              fpu_data1  <= w_d1[w_gnt_idx];
              fpu_data2  <= w_d2[w_gnt_idx];
              fpu_data3  <= w_d3[w_gnt_idx];
              fpu_rm     <= w_rm[w_gnt_idx];
              fpu_opcode <= w_sel_op;
              fpu_cvt_op <= w_cvt[w_gnt_idx];
              fpu_enable <= 1'b1;
              r_state    <= c_issue;
            end else begin
              // Malformed opcode never reaches the unit; answer as invalid.
              rsp_valid   <= w_gnt_oh;
              rsp_result  <= '0;
              rsp_flags   <= c_flags_nv;
              rsp_timeout <= 1'b0;
              r_state     <= c_resp;
            end
          end
        end
        c_issue: begin
          fpu_enable <= 1'b0;
          r_cnt      <= '0;
          r_state    <= c_wait;
        end
        c_wait: begin
          if (fpu_ready) begin
            rsp_valid   <= w_gid_oh;
            rsp_result  <= fpu_result;
            rsp_flags   <= fpu_flags;
            rsp_timeout <= 1'b0;
            r_state     <= c_resp;
          end else if (w_cnt_next == 17'(TIMEOUT)) begin
            rsp_valid   <= w_gid_oh;
            rsp_result  <= c_qnan;
            rsp_flags   <= c_flags_nv;
            rsp_timeout <= 1'b1;
            r_state     <= c_resp;
          end else begin
            r_cnt <= w_cnt_next[15:0];
          end
        end
        c_resp: begin
          if (rsp_ready[r_gid]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            r_state   <= c_idle;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
